// File: rtl/enc_pkg.sv
// Shared types and constants for the sequential 8-to-3 priority encoder.
package enc_pkg;

  localparam int ENC_WIDTH = 8;
  localparam int ENC_IDX_W = 3;

  typedef enum logic [0:0] {
    ENC_IDLE = 1'b0,
    ENC_BUSY = 1'b1
  } enc_state_t;

  // One-hot mask selecting bit idx of a request vector.
  function automatic logic [ENC_WIDTH-1:0] idx_to_mask(input logic [ENC_IDX_W-1:0] idx);
    logic [ENC_WIDTH-1:0] mask;
    mask = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/priority_encoder_8to3_lsb.sv
// Combinational lowest-set-bit finder: index of the lowest set bit, plus
// flags for "exactly one bit set" and "any bit set". Zero latency, no handshake.
module lsb_priority_encoder
  import enc_pkg::*;
(
  input  logic [ENC_WIDTH-1:0] pending,
  output logic [ENC_IDX_W-1:0] idx,
  output logic                 one_hot,
  output logic                 any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        idx = i[ENC_IDX_W-1:0];
      end
    end
  end

  assign any     = |pending;
  assign one_hot = any && ((pending & (pending - ENC_WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_encoder_8to3.sv
// Sequential 8-to-3 encoder: one beat per set bit, lowest first; first beat one cycle after accept.
// Holds the beat while out_ready is low; no accept until the burst ends. ENC_ZERO_FLAG_EN adds out_zero.
module priority_encoder_8to3
  import enc_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH,
  parameter int IDX_W = ENC_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
`ifdef ENC_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  enc_state_t           state;
  enc_state_t           state_nxt;
  logic [WIDTH-1:0]     pending;
  logic [IDX_W-1:0]     low_idx;
  logic                 low_one_hot;
  logic                 low_any;
  logic                 accept;
  logic                 beat;
  logic                 last_beat;

  lsb_priority_encoder u_lsb (
    .pending (pending),
    .idx     (low_idx),
    .one_hot (low_one_hot),
    .any     (low_any)
  );

  assign accept = in_valid && in_ready;
  assign beat   = out_valid && out_ready;

`ifdef ENC_ZERO_FLAG_EN
  // Marks the single synthetic beat produced for an all-zero vector.
  logic zero_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_beat <= 1'b0;
    end else if (accept) begin
      zero_beat <= (in_vec == '0);
    end else if (beat) begin
      zero_beat <= 1'b0;
    end
  end

  assign last_beat = low_one_hot || zero_beat;
`else
  assign last_beat = low_one_hot;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ENC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending bits: loaded on accept, lowest bit retired on each beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (accept) begin
      pending <= in_vec;
    end else if (beat) begin
      pending <= pending & ~idx_to_mask(low_idx);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ENC_IDLE: begin
        if (accept) begin
`ifdef ENC_ZERO_FLAG_EN
          state_nxt = ENC_BUSY;
`else
          if (in_vec != '0) begin
            state_nxt = ENC_BUSY;
          end
`endif
        end
      end
      ENC_BUSY: begin
        if (beat && last_beat) begin
          state_nxt = ENC_IDLE;
        end
      end
      default: state_nxt = ENC_IDLE;
    endcase
  end

  // Outputs depend only on registered state and pending bits (in_ready also on rst).
  always_comb begin
    in_ready  = !rst && (state == ENC_IDLE);
    busy      = (state == ENC_BUSY);
    out_valid = busy;
    out_idx   = busy ? low_idx : '0;
    out_last  = busy && last_beat;
`ifdef ENC_ZERO_FLAG_EN
    out_zero  = busy && zero_beat;
`endif
  end

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed, table-driven bench for priority_encoder_8to3 (default and ENC_ZERO_FLAG_EN builds).
module tb_priority_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;
`ifdef ENC_ZERO_FLAG_EN
  logic       out_zero;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  priority_encoder_8to3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
`ifdef ENC_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  typedef struct {
    logic [7:0]  vec;
    int          nbeats;
    logic [23:0] seq;   // beat k index in seq[3k +: 3]
  } vec_rec_t;

  vec_rec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a vector for one cycle; it must be accepted on the next edge.
  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    chk("in_ready_before_accept", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_vec   = 8'h00;
  endtask

  task automatic chk_beat(input string name, input int idx, input int last);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_idx"}, int'(out_idx), idx);
    chk({name, "_last"}, int'(out_last), last);
    chk({name, "_in_ready"}, int'(in_ready), 0);
`ifdef ENC_ZERO_FLAG_EN
    chk({name, "_zero"}, int'(out_zero), 0);
`endif
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_out_valid"}, int'(out_valid), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] s;

    tbl[0] = '{8'b0010_0000, 1, {21'd0, 3'd5}};
    tbl[1] = '{8'hFF,        8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    tbl[2] = '{8'b1000_0001, 2, {18'd0, 3'd7, 3'd0}};
    tbl[3] = '{8'b0101_0100, 3, {15'd0, 3'd6, 3'd4, 3'd2}};
    tbl[4] = '{8'b0000_0001, 1, {21'd0, 3'd0}};
    tbl[5] = '{8'b1000_0000, 1, {21'd0, 3'd7}};
    tbl[6] = '{8'b0011_1000, 3, {15'd0, 3'd5, 3'd4, 3'd3}};

    // Reset hold with an aggressive requester
    rst = 1'b1; in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_out_last", int'(out_last), 0);
    end
    rst = 1'b0; in_valid = 1'b0; in_vec = 8'h00;
    #1;
    chk("release_in_ready", int'(in_ready), 1);
    tick();
    chk_idle("post_release");

    // Table: free-flowing consumer
    for (int t = 0; t < 7; t++) begin
      s = tbl[t].seq;
      send(tbl[t].vec);
      for (int k = 0; k < tbl[t].nbeats; k++) begin
        chk_beat($sformatf("tbl%0d_beat%0d", t, k), int'(s[3*k +: 3]), (k == tbl[t].nbeats - 1) ? 1 : 0);
        tick();
      end
      chk_idle($sformatf("tbl%0d_end", t));
    end

    // Multi-bit with stall; a competing request during the burst must be ignored
    send(8'b1000_0101);
    out_ready = 1'b1;
    chk_beat("stall_b0", 0, 0);
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_vec = 8'h02;
    chk_beat("stall_b1", 2, 0);
    tick();
    out_ready = 1'b1;
    chk_beat("stall_b1_held", 2, 0);
    tick();
    in_valid = 1'b0; in_vec = 8'h00;
    chk_beat("stall_b2", 7, 1);
    tick();
    chk_idle("stall_end");
    tick();
    chk_idle("stall_no_extra");

    // Zero vector
    send(8'h00);
`ifdef ENC_ZERO_FLAG_EN
    chk("zero_valid", int'(out_valid), 1);
    chk("zero_idx", int'(out_idx), 0);
    chk("zero_last", int'(out_last), 1);
    chk("zero_flag", int'(out_zero), 1);
    tick();
    chk_idle("zero_end");
    chk("zero_flag_clear", int'(out_zero), 0);
`else
    chk_idle("zero_dropped");
    tick();
    chk_idle("zero_dropped_2");
`endif

    // Reset mid-burst
    send(8'hF0);
    chk_beat("mid_b0", 4, 0);
    tick();
    chk_beat("mid_b1", 5, 0);
    tick();
    chk_beat("mid_b2_pending", 6, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    tick();
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_idx", int'(out_idx), 0);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk_idle($sformatf("mid_after_%0d", c));
      tick();
    end

    // Normal traffic after a mid-burst reset
    send(8'b0000_0110);
    chk_beat("recover_b0", 1, 0);
    tick();
    chk_beat("recover_b1", 2, 1);
    tick();
    chk_idle("recover_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
